// File: rtl/square_line_renderer.sv
// Renders one scanline of the square grid into a double-buffered line buffer.
// The front buffer is read combinationally by the VGA streamer; the back buffer is painted one pixel per cycle.
module square_line_renderer #(
    parameter int unsigned LINE_W       = 401,
    parameter int unsigned LINES        = 480,
    parameter int unsigned SQ_SIZE      = 40,
    parameter logic [23:0] BORDER_COLOR = 24'h202020
) (
    input  logic        clock_vga_i,
    input  logic        reset_i,
    input  logic        next_row_i,
    input  logic        next_screen_i,
    input  logic [9:0]  address_i,
    output logic [23:0] data_o,
    output logic [3:0]  cell_x_o,
    output logic [3:0]  cell_y_o,
    output logic        cell_rd_o,
    input  logic [23:0] cell_color_i,
    output logic        busy_o,
    output logic        underrun_o
);

    localparam int unsigned XW = $clog2(LINE_W);
    localparam int unsigned YW = $clog2(LINES);
    localparam int unsigned PW = $clog2(SQ_SIZE);
    localparam logic [XW-1:0] XLast   = XW'(LINE_W - 1);
    localparam logic [YW-1:0] YLast   = YW'(LINES - 1);
    localparam logic [PW-1:0] PLast   = PW'(SQ_SIZE - 1);
    localparam logic [9:0]    AddrLim = 10'(LINE_W);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StPaint} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [PW-1:0] px_q, px_d;
    logic [3:0]    cx_q, cx_d;
    logic [YW-1:0] y_q, y_d;
    logic [PW-1:0] py_q, py_d;
    logic [3:0]    cy_q, cy_d;
    logic [23:0]   color_q, color_d;
    logic          row_q, scr_q;
    logic          front_sel_q, front_sel_d;
    logic          front_valid_q, front_valid_d;
    logic          underrun_q, underrun_d;

    logic          ev_row, ev_scr, ev_any;
    logic          we;
    logic [23:0]   wdata;

    logic [23:0]   buf0 [LINE_W];
    logic [23:0]   buf1 [LINE_W];

    assign ev_row = next_row_i & ~row_q;
    assign ev_scr = next_screen_i & ~scr_q;
    assign ev_any = ev_row | ev_scr;

    assign busy_o     = (state_q != StIdle);
    assign cell_rd_o  = (state_q == StFetch);
    assign cell_x_o   = cx_q;
    assign cell_y_o   = cy_q;
    assign underrun_o = underrun_q;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        px_d          = px_q;
        cx_d          = cx_q;
        y_d           = y_q;
        py_d          = py_q;
        cy_d          = cy_q;
        color_d       = color_q;
        front_sel_d   = front_sel_q;
        front_valid_d = front_valid_q;
        underrun_d    = underrun_q;
        we            = 1'b0;
        wdata         = (px_q == '0 || py_q == '0) ? BORDER_COLOR : color_q;

        if (ev_row) begin
            front_sel_d   = ~front_sel_q;
            front_valid_d = 1'b1;
            if (busy_o) underrun_d = 1'b1;
        end

        // py/cell_y track y as counters so no divider is needed
        if (ev_scr || (ev_row && y_q == YLast)) begin
            y_d  = '0;
            py_d = '0;
            cy_d = '0;
        end else if (ev_row) begin
            y_d = y_q + 1'b1;
            if (py_q == PLast) begin
                py_d = '0;
                cy_d = cy_q + 1'b1;
            end else begin
                py_d = py_q + 1'b1;
            end
        end

        if (ev_any) begin
            // An event aborts the current render; the pending pixel write is dropped.
            state_d = StFetch;
            x_d     = '0;
            px_d    = '0;
            cx_d    = '0;
        end else begin
            unique case (state_q)
                StIdle:  ;
                StFetch: state_d = StWait;
                StWait: begin
                    color_d = cell_color_i;
                    state_d = StPaint;
                end
                StPaint: begin
                    we = 1'b1;
                    if (x_q == XLast) begin
                        state_d = StIdle;
                    end else begin
                        x_d = x_q + 1'b1;
                        if (px_q == PLast) begin
                            px_d    = '0;
                            cx_d    = cx_q + 1'b1;
                            state_d = StFetch;
                        end else begin
                            px_d = px_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_vga_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            x_q           <= '0;
            px_q          <= '0;
            cx_q          <= '0;
            y_q           <= '0;
            py_q          <= '0;
            cy_q          <= '0;
            color_q       <= '0;
            row_q         <= 1'b0;
            scr_q         <= 1'b0;
            front_sel_q   <= 1'b0;
            front_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            px_q          <= px_d;
            cx_q          <= cx_d;
            y_q           <= y_d;
            py_q          <= py_d;
            cy_q          <= cy_d;
            color_q       <= color_d;
            row_q         <= next_row_i;
            scr_q         <= next_screen_i;
            front_sel_q   <= front_sel_d;
            front_valid_q <= front_valid_d;
            underrun_q    <= underrun_d;
        end
    end

    // front_sel_q==0 shows buf0, so the back buffer is buf1
    always_ff @(posedge clock_vga_i) begin
        if (we && !reset_i) begin
            if (front_sel_q) buf0[x_q] <= wdata;
            else             buf1[x_q] <= wdata;
        end
    end

    always_comb begin
        data_o = '0;
        if (front_valid_q && address_i < AddrLim) begin
            data_o = front_sel_q ? buf1[address_i[XW-1:0]] : buf0[address_i[XW-1:0]];
        end
    end

endmodule

// File: tb/tb_square_line_renderer.sv
// Bench for square_line_renderer: fixed vectors for the grid corners plus randomised
// tile maps and event sequences checked against a per-pixel line model.
module tb_square_line_renderer;
    localparam int LW = 401;
    localparam int NL = 480;
    localparam int SQ = 40;
    localparam logic [23:0] BC    = 24'h202020;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;

    logic        clk = 1'b0;
    logic        rst, nrow, nscr, crd, busy, und;
    logic [9:0]  addr;
    logic [23:0] data, ccol;
    logic [3:0]  cx, cy;

    always #5 clk = ~clk;

    square_line_renderer dut (
        .clock_vga_i  (clk),
        .reset_i      (rst),
        .next_row_i   (nrow),
        .next_screen_i(nscr),
        .address_i    (addr),
        .data_o       (data),
        .cell_x_o     (cx),
        .cell_y_o     (cy),
        .cell_rd_o    (crd),
        .cell_color_i (ccol),
        .busy_o       (busy),
        .underrun_o   (und)
    );

    // Tile map: colour valid exactly one cycle after the read strobe.
    logic [23:0] tile [16][16];
    int          fetch_total = 0;
    int          fy_bad = 0;
    logic [3:0]  exp_fy = '0;
    always @(posedge clk) begin
        if (crd === 1'b1) begin
            ccol        <= tile[cy][cx];
            fetch_total <= fetch_total + 1;
            if (cy != exp_fy) fy_bad <= fy_bad + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    int fetch_base, bad_base;

    // Line model: expected contents of front and back buffers.
    int          m_y;
    logic        m_fv;
    logic [23:0] m_front [LW];
    logic [23:0] m_back  [LW];

    typedef struct {
        int          a;
        logic [23:0] exp;
    } vec_t;
    vec_t t2v [6];
    vec_t t3v [8];

    function automatic logic [23:0] pix(input int x, input int y);
        if (x % SQ == 0 || y % SQ == 0) return BC;
        return tile[y / SQ][x / SQ];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input int a, output logic [23:0] d);
        addr = 10'(a);
        #1;
        d = data;
    endtask

    task automatic ev(input bit r, input bit s, input int hold);
        nrow = r;
        nscr = s;
        tick();
        if (r) begin
            m_front = m_back;
            m_fv    = 1'b1;
        end
        if (s) m_y = 0;
        else if (r) m_y = (m_y + 1) % NL;
        for (int x = 0; x < LW; x++) m_back[x] = pix(x, m_y);
        exp_fy     = 4'(m_y / SQ);
        fetch_base = fetch_total;
        bad_base   = fy_bad;
        repeat (hold - 1) tick();
        nrow = 1'b0;
        nscr = 1'b0;
    endtask

    task automatic check_render(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_fetches"}, 32'(fetch_total - fetch_base), 32'd11);
        chk({name, "_cell_y"}, 32'(fy_bad - bad_base), 32'd0);
    endtask

    task automatic check_front(input string name, input int n);
        logic [23:0] d, e;
        int a;
        for (int i = 0; i < n; i++) begin
            a = (i == 0) ? 1 : int'($urandom_range(0, 1023));
            e = (m_fv && a < LW) ? m_front[a] : 24'h0;
            rd(a, d);
            chk(name, 32'(d), 32'(e));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] d;
        int n, r;

        t2v[0] = '{0, BC};   t2v[1] = '{1, BC};   t2v[2] = '{39, BC};
        t2v[3] = '{400, BC}; t2v[4] = '{401, 0};  t2v[5] = '{1023, 0};
        t3v[0] = '{40, BC};  t3v[1] = '{41, GREEN}; t3v[2] = '{79, GREEN};
        t3v[3] = '{60, GREEN}; t3v[4] = '{80, BC}; t3v[5] = '{81, RED};
        t3v[6] = '{0, BC};   t3v[7] = '{1, RED};

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) tile[i][j] = RED;
        m_y = 0;
        m_fv = 1'b0;
        for (int x = 0; x < LW; x++) m_back[x] = '0;

        // T1: reset state
        rst = 1'b1; nrow = 1'b0; nscr = 1'b0; addr = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("t1_busy", 32'(busy), 0);
        chk("t1_underrun", 32'(und), 0);
        chk("t1_cell_rd", 32'(crd), 0);
        chk("t1_cell_xy", 32'({cx, cy}), 0);
        for (int a = 0; a < LW; a++) begin
            rd(a, d);
            chk("t1_data", 32'(d), 0);
        end

        // T2: first screen render takes 423 cycles, then line 0 is all border
        ev(1'b0, 1'b1, 1);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        chk("t2_busy_cycles", 32'(n), 32'd423);
        check_render("t2_render");
        ev(1'b1, 1'b0, 1);
        for (int i = 0; i < 6; i++) begin
            rd(t2v[i].a, d);
            chk("t2_vec", 32'(d), 32'(t2v[i].exp));
        end
        repeat (430) tick();

        // T3: line 41 shows cell (1,1)
        tile[1][1] = GREEN;
        while (m_y != 41) begin
            ev(1'b1, 1'b0, 1);
            repeat (430) tick();
        end
        check_render("t3_render");
        ev(1'b1, 1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            rd(t3v[i].a, d);
            chk("t3_vec", 32'(d), 32'(t3v[i].exp));
        end
        check_front("t3_model", 6);
        repeat (430) tick();

        // T4a: a long next_row level is a single event (78 -> 79, not 83)
        while (m_y != 78) begin
            ev(1'b1, 1'b0, 1);
            repeat (430) tick();
        end
        ev(1'b1, 1'b0, 5);
        repeat (430) tick();
        check_render("t4_hold_render");
        chk("t4_underrun", 32'(und), 0);
        ev(1'b1, 1'b0, 1);
        rd(41, d);
        chk("t4_line79", 32'(d), 32'(GREEN));
        check_front("t4_model", 6);
        repeat (430) tick();

        // T5: swap 100 cycles into a render
        ev(1'b1, 1'b0, 1);
        repeat (100) tick();
        ev(1'b1, 1'b0, 1);
        chk("t5_underrun_set", 32'(und), 1);
        repeat (430) tick();
        check_render("t5_render");
        ev(1'b1, 1'b0, 1);
        check_front("t5_model", 8);
        repeat (430) tick();
        ev(1'b1, 1'b0, 1);
        repeat (430) tick();
        chk("t5_underrun_sticky", 32'(und), 1);

        // T4b: y wraps 479 -> 0
        forever begin
            ev(1'b1, 1'b0, 1);
            if (m_y == NL - 1) begin
                repeat (430) tick();
                check_render("t4_line479");
            end else if (m_y == 0) begin
                break;
            end else begin
                tick();
            end
        end
        repeat (430) tick();
        check_render("t4_wrap_render");
        ev(1'b1, 1'b0, 1);
        check_front("t4_wrap_model", 6);
        repeat (430) tick();

        // T6: simultaneous row and screen events at y=200
        while (m_y != 199) begin
            ev(1'b1, 1'b0, 1);
            tick();
        end
        repeat (430) tick();
        ev(1'b1, 1'b0, 1);
        repeat (430) tick();
        check_front("t6_line199", 4);
        ev(1'b1, 1'b1, 1);
        rd(1, d);
        chk("t6_swap", 32'(d), 32'(BC));
        check_front("t6_line200", 4);
        repeat (430) tick();
        check_render("t6_render0");
        ev(1'b1, 1'b0, 1);
        check_front("t6_line0", 4);
        repeat (30) tick();
        chk("t6_painting", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_reset_busy", 32'(busy), 0);
        rd(5, d);
        chk("t6_reset_data", 32'(d), 0);
        chk("t6_reset_underrun", 32'(und), 0);
        m_fv = 1'b0;
        m_y  = 0;

        // Random tile maps and event mix
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) tile[i][j] = 24'($urandom);
            r = (it == 0) ? 0 : int'($urandom_range(0, 9));
            if (r < 2)       ev(1'b0, 1'b1, 1);
            else if (r == 2) ev(1'b1, 1'b1, 1);
            else             ev(1'b1, 1'b0, int'($urandom_range(1, 3)));
            repeat (430) tick();
            check_render("rnd_render");
            check_front("rnd_data", 6);
        end
        chk("rnd_underrun", 32'(und), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
